ram_dump_uart: RTL and testbench

Read-side companion to the RAM write controller: on a start pulse it sweeps all 256 locations of the 256x8 single-port RAM through its read port and sends each byte out as 8N1 UART serial, address 0 first. It sits beside the write controller on the same RAM. A top-level mux, outside this block, gives the RAM read port to this block while `busy` is high. Its intended use is dumping RAM contents to a host terminal for inspection.

---
 rtl/ram_dump_uart.sv | 167 ++++++++++++++++
 tb/tb_ram_dump_uart.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dump_uart.sv
// ram_dump_uart
// Sweeps all 256 locations of a 256x8 single-port RAM through its read port
// after a start pulse and sends each byte out as an 8N1 UART frame, address 0
// first. It is intended for dumping RAM contents to a host terminal.
//
// Ports:
//   sys_clk   in   system clock, all logic on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   one-cycle request pulse, ignored while busy
//   ram_rden  out  RAM read enable, one cycle per byte
//   ram_addr  out  RAM address, holds the last issued address between reads
//   ram_q     in   RAM read data, valid RD_LATENCY cycles after ram_rden
//   tx        out  UART serial output, registered, idles high
//   busy      out  high from acceptance of start until the last stop bit ends
//   done      out  one-cycle pulse after the 256th stop bit completes
`timescale 1ns/1ps

module ram_dump_uart #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int RD_LATENCY = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       start,
  output logic       ram_rden,
  output logic [7:0] ram_addr,
  input  logic [7:0] ram_q,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BAUD_W   = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  // RD_WAIT lasts RD_LATENCY-1 cycles; the counter's terminal value is one
  // less than that. With RD_LATENCY=1 the state is bypassed entirely.
  localparam logic [1:0] WAIT_LAST = (RD_LATENCY >= 2) ? 2'(RD_LATENCY - 2) : 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    LOAD,
    SEND,
    FIN
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          addr_q, addr_d;
  logic [1:0]          wait_cnt_q, wait_cnt_d;
  logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [9:0]          frame_q, frame_d;
  logic                tx_q, tx_d;

  // State and datapath registers. Reset parks the line high and abandons any
  // dump in progress without producing done.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 8'd0;
      wait_cnt_q <= 2'd0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      frame_q    <= 10'h3FF;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wait_cnt_q <= wait_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state and datapath logic. tx_d always carries the bit that the line
  // must show in the following cycle, so tx is a plain flop output.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wait_cnt_d = wait_cnt_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    tx_d       = tx_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          addr_d  = 8'd0;
          state_d = RD_REQ;
        end
      end

      RD_REQ: begin
        wait_cnt_d = 2'd0;
        if (RD_LATENCY == 1) begin
          state_d = LOAD;
        end else begin
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end

      // The start bit goes out on the same edge the frame is captured.
      LOAD: begin
        frame_d    = {1'b1, ram_q, 1'b0};
        tx_d       = 1'b0;
        baud_cnt_d = '0;
        bit_cnt_d  = 4'd0;
        state_d    = SEND;
      end

      SEND: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            tx_d = 1'b1;
            // Checking for 255 before incrementing keeps address 0 from
            // ever being reissued within one dump.
            if (addr_q == 8'hFF) begin
              state_d = FIN;
            end else begin
              addr_d  = addr_q + 8'd1;
              state_d = RD_REQ;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            frame_d   = {1'b1, frame_q[9:1]};
            tx_d      = frame_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      // start is not looked at here, so a request coinciding with done is
      // dropped.
      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_rden = (state_q == RD_REQ);
  assign ram_addr = addr_q;
  assign tx       = tx_q;
  assign done     = (state_q == FIN);
  assign busy     = (state_q != IDLE) && (state_q != FIN);

endmodule

// File: tb/tb_ram_dump_uart.sv
// tb_ram_dump_uart
// Directed bench for ram_dump_uart. Two instances share clock and reset: dut_a
// uses a 2-cycle registered RAM model, dut_b a 1-cycle one. Both models
// return mem[i] = i ^ 8'hA5. Inputs change on the falling edge and outputs
// are sampled on the falling edge, away from the active rising edge.
`timescale 1ns/1ps

module tb_ram_dump_uart;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int BD       = 10;
  localparam int LAT_A    = 2;
  localparam int LAT_B    = 1;
  localparam int P_A      = 10 * BD + LAT_A + 1;
  localparam int P_B      = 10 * BD + LAT_B + 1;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic       rden_a, rden_b;
  logic [7:0] addr_a, addr_b;
  logic [7:0] q_a, q_b;
  logic [7:0] stage_a;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int checks   = 0;
  int failures = 0;

  ram_dump_uart #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .RD_LATENCY(LAT_A)
  ) dut_a (
    .sys_clk (clk),
    .rst     (rst),
    .start   (start_a),
    .ram_rden(rden_a),
    .ram_addr(addr_a),
    .ram_q   (q_a),
    .tx      (tx_a),
    .busy    (busy_a),
    .done    (done_a)
  );

  ram_dump_uart #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .RD_LATENCY(LAT_B)
  ) dut_b (
    .sys_clk (clk),
    .rst     (rst),
    .start   (start_b),
    .ram_rden(rden_b),
    .ram_addr(addr_b),
    .ram_q   (q_b),
    .tx      (tx_b),
    .busy    (busy_b),
    .done    (done_b)
  );

  // 100 MHz simulation clock; the absolute period is irrelevant to the design.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 2-cycle RAM: address register followed by an output register.
  always @(posedge clk) begin
    if (rden_a) stage_a <= addr_a ^ 8'hA5;
    q_a <= stage_a;
  end

  // 1-cycle RAM: single registered read.
  always @(posedge clk) begin
    if (rden_b) q_b <= addr_b ^ 8'hA5;
  end

  // Safety net in case a bounded loop is ever miscounted.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge right after the
  // rising edge that sampled start (cycle offset j=0).
  task automatic pulse_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    start_a = 1'b0;
    start_b = 1'b0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx_a got=%b want=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_a got=%b want=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_done_a got=%b want=0", done_a); end
    checks++; if (rden_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_rden_a got=%b want=0", rden_a); end
    checks++; if (addr_a !== 8'h00) begin failures++; $display("[TB] FAIL reset_addr_a got=%h want=00", addr_a); end
    checks++; if (tx_b !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx_b got=%b want=1", tx_b); end
    checks++; if (busy_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_b got=%b want=0", busy_b); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy_a !== 1'b0 || tx_a !== 1'b1) begin failures++; $display("[TB] FAIL idle_after_reset got busy=%b tx=%b want busy=0 tx=1", busy_a, tx_a); end
  endtask

  task automatic test_single_start();
    logic [9:0] exp_frame;
    logic       exp_tx;
    exp_frame = {1'b1, 8'hA5, 1'b0};
    pulse_a();
    for (int j = 0; j <= P_A; j++) begin
      if (j == 0) begin
        checks++; if (rden_a !== 1'b1) begin failures++; $display("[TB] FAIL first_rden got=%b want=1", rden_a); end
        checks++; if (addr_a !== 8'h00) begin failures++; $display("[TB] FAIL first_addr got=%h want=00", addr_a); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("[TB] FAIL busy_on_accept got=%b want=1", busy_a); end
      end
      if (j == 1) begin
        checks++; if (rden_a !== 1'b0) begin failures++; $display("[TB] FAIL rden_one_cycle got=%b want=0", rden_a); end
      end
      if (j >= LAT_A + 1 && j < LAT_A + 1 + 10 * BD) exp_tx = exp_frame[(j - LAT_A - 1) / BD];
      else exp_tx = 1'b1;
      checks++; if (tx_a !== exp_tx) begin failures++; $display("[TB] FAIL single_tx j=%0d got=%b want=%b", j, tx_a, exp_tx); end
      if (j == P_A) begin
        checks++; if (rden_a !== 1'b1 || addr_a !== 8'h01) begin failures++; $display("[TB] FAIL second_read got rden=%b addr=%h want rden=1 addr=01", rden_a, addr_a); end
      end
      @(negedge clk);
    end
    do_reset();
  endtask

  // Full 256-byte dump with extra start pulses at byte 3, byte 255 and in the
  // cycle done is high; none may be accepted.
  task automatic test_full_dump();
    int         frames, dones, done_j, rd_count, addr_errs, busy_after, rx_t;
    logic       rx_active;
    logic [9:0] rx_bits, exp_frame;
    frames = 0; dones = 0; done_j = -1; rd_count = 0; addr_errs = 0;
    busy_after = 0; rx_t = 0; rx_active = 1'b0; rx_bits = '0;
    pulse_a();
    for (int j = 0; j < 256 * P_A + 20; j++) begin
      start_a = (j == 3 * P_A + 20) || (j == 255 * P_A + 50) || (done_a === 1'b1);

      if (rden_a === 1'b1) begin
        if (rd_count >= 256 || addr_a !== 8'(rd_count)) addr_errs++;
        rd_count++;
      end

      if (dones > 0 && busy_a === 1'b1) busy_after++;
      if (j == 256 * P_A - 1) begin
        checks++; if (busy_a !== 1'b1) begin failures++; $display("[TB] FAIL busy_before_done got=%b want=1", busy_a); end
      end
      if (done_a === 1'b1) begin
        dones++;
        if (dones == 1) begin
          done_j = j;
          checks++; if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL busy_with_done got=%b want=0", busy_a); end
        end
      end

      if (!rx_active) begin
        if (tx_a === 1'b0) begin
          rx_active = 1'b1;
          rx_t = 0;
        end
      end else begin
        rx_t++;
      end
      if (rx_active && (rx_t % BD) == BD / 2) rx_bits[rx_t / BD] = tx_a;
      if (rx_active && rx_t == 10 * BD - 1) begin
        rx_active = 1'b0;
        exp_frame = {1'b1, 8'(frames) ^ 8'hA5, 1'b0};
        checks++; if (rx_bits !== exp_frame) begin failures++; $display("[TB] FAIL dump_frame idx=%0d got=%h want=%h", frames, rx_bits, exp_frame); end
        frames++;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    checks++; if (frames != 256) begin failures++; $display("[TB] FAIL frame_count got=%0d want=256", frames); end
    checks++; if (dones != 1) begin failures++; $display("[TB] FAIL done_count got=%0d want=1", dones); end
    checks++; if (done_j != 256 * P_A) begin failures++; $display("[TB] FAIL done_time got=%0d want=%0d", done_j, 256 * P_A); end
    checks++; if (rd_count != 256) begin failures++; $display("[TB] FAIL read_count got=%0d want=256", rd_count); end
    checks++; if (addr_errs != 0) begin failures++; $display("[TB] FAIL addr_sequence errors got=%0d want=0", addr_errs); end
    checks++; if (busy_after != 0) begin failures++; $display("[TB] FAIL busy_after_done cycles got=%0d want=0", busy_after); end
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] byte7;
    int         dones, busy_cnt;
    byte7 = 8'd7 ^ 8'hA5;
    dones = 0; busy_cnt = 0;
    pulse_a();
    // Middle of data bit 4 (frame bit 5) of byte 7.
    repeat (7 * P_A + LAT_A + 1 + 5 * BD + 5) @(negedge clk);
    checks++; if (tx_a !== byte7[4]) begin failures++; $display("[TB] FAIL mid_frame_bit4 got=%b want=%b", tx_a, byte7[4]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin failures++; $display("[TB] FAIL abort_tx got=%b want=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b want=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("[TB] FAIL abort_done got=%b want=0", done_a); end
    checks++; if (addr_a !== 8'h00 || rden_a !== 1'b0) begin failures++; $display("[TB] FAIL abort_read got addr=%h rden=%b want addr=00 rden=0", addr_a, rden_a); end
    rst = 1'b0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (done_a === 1'b1) dones++;
      if (busy_a !== 1'b0) busy_cnt++;
    end
    checks++; if (dones != 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d want=0", dones); end
    checks++; if (busy_cnt != 0) begin failures++; $display("[TB] FAIL abort_stays_idle busy_cycles got=%0d want=0", busy_cnt); end
    pulse_a();
    checks++; if (rden_a !== 1'b1 || addr_a !== 8'h00 || busy_a !== 1'b1) begin failures++; $display("[TB] FAIL restart got rden=%b addr=%h busy=%b want 1 00 1", rden_a, addr_a, busy_a); end
    do_reset();
  endtask

  task automatic test_rd_latency1();
    int         rel, idx;
    logic [9:0] rx_bits, exp_frame;
    rx_bits = '0;
    pulse_b();
    for (int j = 0; j < 3 * P_B + LAT_B + 1; j++) begin
      if (j == 0) begin
        checks++; if (rden_b !== 1'b1 || addr_b !== 8'h00) begin failures++; $display("[TB] FAIL lat1_first_read got rden=%b addr=%h want 1 00", rden_b, addr_b); end
      end
      if (j == LAT_B) begin
        checks++; if (tx_b !== 1'b1) begin failures++; $display("[TB] FAIL lat1_tx_before_start got=%b want=1", tx_b); end
      end
      if (j == LAT_B + 1) begin
        checks++; if (tx_b !== 1'b0) begin failures++; $display("[TB] FAIL lat1_start_bit got=%b want=0", tx_b); end
      end
      if (j == P_B || j == 2 * P_B) begin
        checks++; if (rden_b !== 1'b1 || addr_b !== 8'(j / P_B)) begin failures++; $display("[TB] FAIL lat1_period j=%0d got rden=%b addr=%h want rden=1 addr=%h", j, rden_b, addr_b, 8'(j / P_B)); end
      end
      if (j >= LAT_B + 1) begin
        idx = (j - LAT_B - 1) / P_B;
        rel = (j - LAT_B - 1) % P_B;
        if (rel < 10 * BD && (rel % BD) == BD / 2) rx_bits[rel / BD] = tx_b;
        if (rel == 10 * BD - 1 && idx < 3) begin
          exp_frame = {1'b1, 8'(idx) ^ 8'hA5, 1'b0};
          checks++; if (rx_bits !== exp_frame) begin failures++; $display("[TB] FAIL lat1_frame idx=%0d got=%h want=%h", idx, rx_bits, exp_frame); end
        end
      end
      @(negedge clk);
    end
    do_reset();
  endtask

  initial begin
    rst     = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_start();
    test_full_dump();
    test_reset_mid_frame();
    test_rd_latency1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
